mac_seq: RTL and testbench

- Controller that sits on the other side of the mac pipeline's operand/accumulator interface.
- Accepts a dot-product job (length, bias), streams operand pairs from an upstream valid/ready source into the mac, and inserts zero bubbles when the source stalls.
- Waits out the mac's two-stage pipeline latency, then presents the accumulated result on a valid/ready output.
- Drives mac reset, mac_en_sum, mac_a, mac_b and mac_part_sum; reads mac_f.

---
 rtl/mac_seq.sv | 165 ++++++++++++++++
 tb/tb_mac_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// ---------------------------------------------------------------------------
// mac_seq : sequencer for a two-stage multiply-accumulate pipeline.
//
// Runs one dot-product job at a time. The job length and the bias are
// latched on start. The bias is loaded into the mac accumulator, and then
// operand pairs are streamed from a valid/ready source. A zero operand pair
// is sent whenever the source stalls. The sequencer waits out the mac
// latency and then presents the accumulator on a valid/ready output.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   start/len/bias  job request (sampled only in IDLE)
//   busy            high whenever not IDLE
//   in_valid/in_ready/in_a/in_b        operand stream
//   mac_reset/mac_en_sum/mac_a/mac_b/mac_part_sum  controls to the mac
//   mac_f           mac accumulator value
//   out_valid/out_ready/out_data       result handshake
// ---------------------------------------------------------------------------
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | mac held in reset with a zero accumulator, waiting for start
// LOAD     | mac held in reset, accumulator loaded with the latched bias
// STREAM   | accepting operand pairs, or sending zero bubbles when stalled
// DRAIN    | two cycles of zeros that let the last product reach the sum
// CAPTURE  | register mac_f into out_data
// OUT      | result presented, waiting for out_ready
// ---------------------------------------------------------------------------
module mac_seq #(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int LEN_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic [2*(IL+FL)-1:0]     bias,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IL+FL-1:0]         in_a,
    input  logic [IL+FL-1:0]         in_b,
    output logic                     mac_reset,
    output logic                     mac_en_sum,
    output logic [IL+FL-1:0]         mac_a,
    output logic [IL+FL-1:0]         mac_b,
    output logic [2*(IL+FL)-1:0]     mac_part_sum,
    input  logic [2*(IL+FL)-1:0]     mac_f,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*(IL+FL)-1:0]     out_data
);

    localparam int W  = IL + FL;
    localparam int AW = 2 * W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_CAPTURE,
        S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [AW-1:0]    bias_q, bias_d;
    logic             drain_q, drain_d;
    logic             out_valid_q, out_valid_d;
    logic [AW-1:0]    out_data_q, out_data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            count_q     <= '0;
            bias_q      <= '0;
            drain_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            bias_q      <= bias_d;
            drain_q     <= drain_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        bias_d      = bias_q;
        drain_d     = drain_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        busy       = (state_q != S_IDLE);
        in_ready   = (state_q == S_STREAM);
        // While reset is high the mac is also held in reset, so an
        // abandoned job leaves nothing behind in the accumulator.
        mac_reset  = reset || (state_q == S_IDLE) || (state_q == S_LOAD);
        mac_en_sum = (state_q == S_LOAD);
        mac_a      = '0;
        mac_b      = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    bias_d  = bias;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = '0;
                drain_d = 1'b0;
                state_d = (len_q != '0) ? S_STREAM : S_DRAIN;
            end
            S_STREAM: begin
                // A stalled source leaves mac_a/mac_b at zero. The bubble
                // adds nothing to the accumulator.
                if (in_valid) begin
                    mac_a   = in_a;
                    mac_b   = in_b;
                    count_d = count_q + 1'b1;
                    if (count_q == len_q - 1'b1) begin
                        drain_d = 1'b0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                out_data_d  = mac_f;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mac_part_sum = bias_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq. It provides a behavioural two-stage mac and checks
// each job against the bias plus the sum of operand products, taken
// modulo 2^40.
module tb_mac_seq;

    localparam int IL    = 4;
    localparam int FL    = 16;
    localparam int LEN_W = 8;
    localparam int W     = IL + FL;
    localparam int AW    = 2 * W;

    logic             clk;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [AW-1:0]    bias;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             mac_reset;
    logic             mac_en_sum;
    logic [W-1:0]     mac_a;
    logic [W-1:0]     mac_b;
    logic [AW-1:0]    mac_part_sum;
    logic [AW-1:0]    mac_f;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_data;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic signed [W-1:0] pa[$];
    logic signed [W-1:0] pb[$];
    int                  gq[$];

    mac_seq #(.IL(IL), .FL(FL), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .len          (len),
        .bias         (bias),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .mac_reset    (mac_reset),
        .mac_en_sum   (mac_en_sum),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_part_sum (mac_part_sum),
        .mac_f        (mac_f),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural mac: operands sampled at E, product at E+1, sum at E+2.
    logic signed [W-1:0]  m_a, m_b;
    logic signed [AW-1:0] m_prod;
    logic [AW-1:0]        m_acc;

    always @(posedge clk) begin
        if (mac_reset) begin
            m_a    <= '0;
            m_b    <= '0;
            m_prod <= '0;
            m_acc  <= mac_en_sum ? mac_part_sum : '0;
        end else begin
            m_a    <= mac_a;
            m_b    <= mac_b;
            m_prod <= m_a * m_b;
            m_acc  <= m_acc + m_prod;
        end
    end
    assign mac_f = m_acc;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic run_job(input int n, input logic [AW-1:0] b, input int hold,
                           input bit pulse, output logic [AW-1:0] res);
        longint        acc;
        int            s_cyc, hs_cyc, exp_cyc, waited;
        logic [AW-1:0] expv, held;
        acc = longint'($signed(b));
        for (int i = 0; i < n; i++) acc += longint'(pa[i]) * longint'(pb[i]);
        expv = acc[AW-1:0];

        start = 1'b1;
        len   = n[LEN_W-1:0];
        bias  = b;
        @(negedge clk);
        start = 1'b0;
        s_cyc = cyc;
        chk("load_busy", busy, 1);
        chk("load_mac_reset", mac_reset, 1);
        chk("load_en_sum", mac_en_sum, 1);
        chk("load_part_sum", mac_part_sum, b);
        chk("load_in_ready", in_ready, 0);
        @(negedge clk);
        hs_cyc = s_cyc;

        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gq[i]; g++) begin
                in_valid = 1'b0;
                in_a = W'($urandom);
                in_b = W'($urandom);
                #1;
                chk("gap_in_ready", in_ready, 1);
                chk("gap_mac_a", mac_a, 0);
                chk("gap_mac_b", mac_b, 0);
                chk("gap_mac_reset", mac_reset, 0);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_a = pa[i];
            in_b = pb[i];
            #1;
            chk("hs_in_ready", in_ready, 1);
            chk("hs_mac_a", mac_a, $unsigned(pa[i]));
            chk("hs_mac_b", mac_b, $unsigned(pb[i]));
            @(negedge clk);
            hs_cyc = cyc;
        end

        exp_cyc = (n > 0) ? hs_cyc + 3 : s_cyc + 4;
        // A valid source outside STREAM must be ignored.
        waited = 0;
        while (!out_valid && waited < 20) begin
            in_valid = 1'b1;
            in_a = W'($urandom);
            in_b = W'($urandom);
            #1;
            chk("drain_in_ready", in_ready, 0);
            chk("drain_mac_a", mac_a, 0);
            chk("drain_mac_b", mac_b, 0);
            @(negedge clk);
            waited++;
        end
        in_valid = 1'b0;
        chk("out_valid_seen", out_valid, 1);
        chk("latency_cycle", cyc, exp_cyc);
        chk("result", out_data, expv);
        res  = out_data;
        held = out_data;

        for (int h = 0; h < hold; h++) begin
            start = pulse;
            @(negedge clk);
            start = 1'b0;
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, held);
            chk("hold_busy", busy, 1);
        end
        out_ready = 1'b1;
        start = pulse;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        chk("ret_out_valid", out_valid, 0);
        chk("ret_busy", busy, 0);
        chk("ret_mac_reset", mac_reset, 1);
        @(negedge clk);
        chk("start_ignored", busy, 0);
    endtask

    logic [AW-1:0] r;

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; bias = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_mac_reset", mac_reset, 1);
        chk("rst_en_sum", mac_en_sum, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_part_sum", mac_part_sum, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Three pairs back to back
        pa = '{20'sd2, -20'sd1, 20'sd4};
        pb = '{20'sd3, 20'sd5, 20'sd4};
        gq = '{0, 0, 0};
        run_job(3, 40'd10, 0, 1'b0, r);
        chk("dot3", r, 40'd27);

        // Same job with a 2-cycle stall between pair 1 and pair 2
        gq = '{0, 2, 0};
        run_job(3, 40'd10, 0, 1'b0, r);
        chk("dot3_gap", r, 40'd27);

        // Empty job: the result is the bias itself
        pa.delete(); pb.delete(); gq.delete();
        run_job(0, -40'sd7, 0, 1'b0, r);
        chk("len0", r, 40'hFF_FFFF_FFF9);

        // Accumulator wrap
        pa = '{20'sh80000, 20'sh80000};
        pb = '{20'sh80000, 20'sh80000};
        gq = '{0, 0};
        run_job(2, 40'd0, 0, 1'b0, r);
        chk("wrap", r, 40'h80_0000_0000);

        // Output back-pressure while start is pulsed
        pa = '{20'sd7};
        pb = '{-20'sd3};
        gq = '{1};
        run_job(1, 40'd100, 5, 1'b1, r);
        chk("backpressure", r, 40'd79);

        // Reset after the first pair of a 4-pair job
        start = 1'b1; len = 8'd4; bias = 40'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_a = 20'd1; in_b = 20'd2;
        @(negedge clk);
        reset = 1'b1;
        in_a = 20'd9; in_b = 20'd9;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_mac_reset", mac_reset, 1);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_part_sum", mac_part_sum, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_busy", busy, 0);
        pa = '{20'sd3};
        pb = '{20'sd3};
        gq = '{0};
        run_job(1, 40'd1, 0, 1'b0, r);
        chk("after_reset", r, 40'd10);

        // Random jobs with random stalls
        for (int j = 0; j < 5; j++) begin
            int n;
            logic [AW-1:0] rb;
            n = int'($urandom_range(1, 8));
            pa.delete(); pb.delete(); gq.delete();
            for (int i = 0; i < n; i++) begin
                pa.push_back(W'($urandom));
                pb.push_back(W'($urandom));
                gq.push_back(int'($urandom_range(0, 2)));
            end
            rb = {8'($urandom), 32'($urandom)};
            run_job(n, rb, int'($urandom_range(0, 3)), 1'($urandom), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
